// File: rtl/irq_pending4_if.sv
// Request/acknowledge bundle between the control side and the irq_pending4 capture stage.
// The control side drives requests, mask, ack and clears; the capture stage returns pend/irq/ovf.
interface irq_pending4_if #(
  parameter int WIDTH = 4
);
  localparam int IDW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] mask;
  logic             ack;
  logic [IDW-1:0]   ack_id;
  logic             clr_ovf;
  logic [WIDTH-1:0] pend;
  logic             irq;
  logic [WIDTH-1:0] ovf;

  modport master (
    output req, mask, ack, ack_id, clr_ovf,
    input  pend, irq, ovf
  );

  modport slave (
    input  req, mask, ack, ack_id, clr_ovf,
    output pend, irq, ovf
  );
endinterface

// File: rtl/irq_pending4.sv
// Four-channel request capture: synchronize, detect rising edges, hold sticky pending bits
// cleared by indexed ack, with per-channel overflow flags. Feeds the downstream priority encoder.
module irq_pending4_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack_hit,
  input  logic clr_ovf,
  output logic pending,
  output logic ovf
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   pending_q, pending_d;
  logic                   ovf_q, ovf_d;
  logic                   edge_det;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], req};
    hist_d    = sync_q[SYNC_STAGES-1];
    edge_det  = sync_q[SYNC_STAGES-1] & ~hist_q;
    // A new edge beats a same-cycle ack: the acked event is consumed, the new one kept.
    pending_d = pending_q;
    if (edge_det)     pending_d = 1'b1;
    else if (ack_hit) pending_d = 1'b0;
    // New overflow wins over the clear issued in the same cycle.
    ovf_d = (clr_ovf ? 1'b0 : ovf_q) | (edge_det & pending_q & ~ack_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pending = pending_q;
  assign ovf     = ovf_q;
endmodule

module irq_pending4 #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  irq_pending4_if.slave bus
);
  localparam int IDW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] ack_hit;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] ovf;

  always_comb begin
    ack_hit = '0;
    for (int n = 0; n < WIDTH; n++)
      ack_hit[n] = bus.ack && (bus.ack_id == IDW'(n));
  end

  for (genvar n = 0; n < WIDTH; n++) begin : g_lane
    irq_pending4_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (bus.req[n]),
      .ack_hit (ack_hit[n]),
      .clr_ovf (bus.clr_ovf),
      .pending (pending[n]),
      .ovf     (ovf[n])
    );
  end

  // Mask only hides channels from the encoder; latching continues underneath.
  assign bus.pend = pending & ~bus.mask;
  assign bus.irq  = |(pending & ~bus.mask);
  assign bus.ovf  = ovf;
endmodule

// File: tb/tb_irq_pending4.sv
// Directed bench for irq_pending4: reset, latency, ack/mask table, overflow, collisions, mid-run reset.
module tb_irq_pending4;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;

  irq_pending4_if #(.WIDTH(4)) bus ();

  irq_pending4 #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ack;
    logic [1:0] ack_id;
    logic [3:0] mask;
    logic [3:0] exp_pend;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[7];

  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  // Drop the selected lines for 4 cycles, raise them, and wait until just before detection.
  task automatic rerise(input logic [3:0] bits, input int wait_edges);
    bus.req = bus.req & ~bits;
    tick(4);
    bus.req = bus.req | bits;
    tick(wait_edges);
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd3, 4'b0000, 4'b0011, 1'b1};
    vecs[1] = '{1'b1, 2'd2, 4'b0000, 4'b0011, 1'b1};
    vecs[2] = '{1'b0, 2'd0, 4'b0010, 4'b0001, 1'b1};
    vecs[3] = '{1'b1, 2'd1, 4'b0010, 4'b0001, 1'b1};
    vecs[4] = '{1'b0, 2'd0, 4'b0001, 4'b0000, 1'b0};
    vecs[5] = '{1'b0, 2'd0, 4'b0000, 4'b0001, 1'b1};
    vecs[6] = '{1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0};

    rst_n = 1'b0;
    bus.req = 4'b0000; bus.mask = 4'b0000; bus.ack = 1'b0;
    bus.ack_id = 2'd0; bus.clr_ovf = 1'b0;
    #12;
    chk("reset_pend", bus.pend, 4'b0000);
    chk("reset_irq", {3'b0, bus.irq}, 4'b0000);
    chk("reset_ovf", bus.ovf, 4'b0000);
    #2 rst_n = 1'b1;
    tick(3);

    // Latency: pending after the third edge, not before
    bus.req = 4'b0100;
    tick(1); chk("lat_e0_pend", bus.pend, 4'b0000);
    tick(1); chk("lat_e1_pend", bus.pend, 4'b0000);
    chk("lat_e1_irq", {3'b0, bus.irq}, 4'b0000);
    tick(1); chk("lat_e2_pend", bus.pend, 4'b0100);
    chk("lat_e2_irq", {3'b0, bus.irq}, 4'b0001);
    bus.ack = 1'b1; bus.ack_id = 2'd2;
    tick(1); bus.ack = 1'b0;
    chk("ack2_clear", bus.pend, 4'b0000);

    // Multi-channel rise
    bus.req = 4'b1011;
    tick(3);
    chk("multi_pend", bus.pend, 4'b1011);

    for (int i = 0; i < 7; i++) begin
      bus.ack = vecs[i].ack; bus.ack_id = vecs[i].ack_id; bus.mask = vecs[i].mask;
      tick(1);
      bus.ack = 1'b0;
      chk($sformatf("vec%0d_pend", i), bus.pend, vecs[i].exp_pend);
      chk($sformatf("vec%0d_irq", i), {3'b0, bus.irq}, {3'b0, vecs[i].exp_irq});
      chk($sformatf("vec%0d_ovf", i), bus.ovf, 4'b0000);
    end

    // Mask is combinational: no clock edge between the checks
    rerise(4'b0001, 3);
    chk("ch0_pending", bus.pend, 4'b0001);
    bus.mask = 4'b0001; #1;
    chk("mask_pend", bus.pend, 4'b0000);
    chk("mask_irq", {3'b0, bus.irq}, 4'b0000);
    bus.mask = 4'b0000; #1;
    chk("unmask_pend", bus.pend, 4'b0001);
    chk("unmask_irq", {3'b0, bus.irq}, 4'b0001);

    // Overflow on channel 1
    rerise(4'b0010, 3);
    chk("ch1_pending", bus.pend, 4'b0011);
    chk("ch1_no_ovf", bus.ovf, 4'b0000);
    rerise(4'b0010, 2);
    chk("ovf_early", bus.ovf, 4'b0000);
    tick(1);
    chk("ovf_set", bus.ovf, 4'b0010);
    chk("ovf_pend_kept", bus.pend, 4'b0011);
    bus.clr_ovf = 1'b1; tick(1); bus.clr_ovf = 1'b0;
    chk("ovf_clr", bus.ovf, 4'b0000);

    // Ack coinciding with a new edge on channel 2
    bus.req = bus.req | 4'b0100;
    tick(3);
    chk("ch2_pending", bus.pend, 4'b0111);
    rerise(4'b0100, 2);
    bus.ack = 1'b1; bus.ack_id = 2'd2;
    tick(1); bus.ack = 1'b0;
    chk("coll_pend", bus.pend, 4'b0111);
    chk("coll_ovf", bus.ovf, 4'b0000);

    // clr_ovf coinciding with a new overflow on channel 0
    rerise(4'b0011, 3);
    chk("ovf01_set", bus.ovf, 4'b0011);
    rerise(4'b0001, 2);
    bus.clr_ovf = 1'b1;
    tick(1); bus.clr_ovf = 1'b0;
    chk("clr_vs_new_ovf", bus.ovf, 4'b0001);

    // Build pend=1111, ovf=0101, then reset between edges
    rerise(4'b1100, 3);
    chk("pre_rst_pend", bus.pend, 4'b1111);
    chk("pre_rst_ovf", bus.ovf, 4'b0101);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pend", bus.pend, 4'b0000);
    chk("mid_rst_irq", {3'b0, bus.irq}, 4'b0000);
    chk("mid_rst_ovf", bus.ovf, 4'b0000);
    bus.req = 4'b1000;
    #1 rst_n = 1'b1;
    tick(2);
    chk("post_rst_e1", bus.pend, 4'b0000);
    tick(1);
    chk("post_rst_e2", bus.pend, 4'b1000);
    chk("post_rst_ovf", bus.ovf, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
